// File: rtl/timing_sequencer.sv
// Timing and run-control unit: HALT/RUN/STEP_WAIT sequencing, T-state counter
// with one-hot decode, interrupt-cycle flop R and instruction-retire counter.
module timing_sequencer #(
    parameter int unsigned NUM_T = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     halt_req,
    input  logic                     step_mode,
    input  logic                     step_req,
    input  logic                     incr_sc,
    input  logic                     clr_sc,
    input  logic                     ien,
    input  logic                     irq_pending,
    input  logic                     clr_r,
    output logic                     advance_en,
    output logic [$clog2(NUM_T)-1:0] sc,
    output logic [NUM_T-1:0]         T,
    output logic                     R,
    output logic                     running,
    output logic                     step_ack,
    output logic                     sc_wrap,
    output logic [CNT_W-1:0]         instr_count
);

    localparam int unsigned SC_W = $clog2(NUM_T);
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(NUM_T - 1);

    localparam logic [1:0] ST_HALT      = 2'd0;
    localparam logic [1:0] ST_RUN       = 2'd1;
    localparam logic [1:0] ST_STEP_WAIT = 2'd2;

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [SC_W-1:0] sc_nxt;
    logic            wrap_hit;
    logic            t_early;
    logic            retire;

    // A step request is honoured in the same cycle it arrives.
    assign step_ack   = (state == ST_STEP_WAIT) && step_req;
    assign advance_en = (state == ST_RUN) || step_ack;
    assign running    = (state != ST_HALT);
    assign retire     = advance_en && (clr_sc || halt_req);

    always_comb begin
        T = '0;
        for (int unsigned i = 0; i < NUM_T; i++) begin
            T[i] = (sc == SC_W'(i));
        end
    end

    // T0..T2 active; written as a compare so NUM_T=2 needs no out-of-range index.
    assign t_early = ({{(32 - SC_W){1'b0}}, sc} < 32'd3);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_HALT: begin
                if (start) begin
                    state_nxt = step_mode ? ST_STEP_WAIT : ST_RUN;
                end
            end
            ST_RUN: begin
                if (halt_req) begin
                    state_nxt = ST_HALT;
                end else if (step_mode) begin
                    state_nxt = ST_STEP_WAIT;
                end
            end
            ST_STEP_WAIT: begin
                if (advance_en && halt_req) begin
                    state_nxt = ST_HALT;
                end else if (!step_mode) begin
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_HALT;
        endcase
    end

    always_comb begin
        sc_nxt   = sc;
        wrap_hit = 1'b0;
        if (advance_en) begin
            if (halt_req || clr_sc) begin
                sc_nxt = '0;
            end else if (incr_sc) begin
                if (sc == SC_MAX) begin
                    sc_nxt   = '0;
                    wrap_hit = 1'b1;
                end else begin
                    sc_nxt = sc + SC_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_HALT;
            sc          <= '0;
            R           <= 1'b0;
            sc_wrap     <= 1'b0;
            instr_count <= '0;
        end else begin
            state <= state_nxt;
            sc    <= sc_nxt;
            if (wrap_hit) begin
                sc_wrap <= 1'b1;
            end
            if (advance_en) begin
                if (clr_r) begin
                    R <= 1'b0;
                end else if (!R && !t_early && ien && irq_pending) begin
                    R <= 1'b1;
                end
            end
            if (retire) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_timing_sequencer.sv
// Directed self-checking bench for timing_sequencer (NUM_T=16 and NUM_T=8 instances).
module tb_timing_sequencer;

    logic clk = 1'b0;
    logic reset;
    logic start, halt_req, step_mode, step_req, incr_sc, clr_sc;
    logic ien, irq_pending, clr_r;

    logic        advance_en, R, running, step_ack, sc_wrap;
    logic [3:0]  sc;
    logic [15:0] T;
    logic [15:0] instr_count;

    logic        advance_en8, R8, running8, step_ack8, sc_wrap8;
    logic [2:0]  sc8;
    logic [7:0]  T8;
    logic [15:0] instr_count8;

    int checks = 0;
    int errors = 0;
    int exp_sc;
    logic exp_ack;

    always #5 clk = ~clk;

    timing_sequencer #(.NUM_T(16), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
        .step_mode(step_mode), .step_req(step_req), .incr_sc(incr_sc),
        .clr_sc(clr_sc), .ien(ien), .irq_pending(irq_pending), .clr_r(clr_r),
        .advance_en(advance_en), .sc(sc), .T(T), .R(R), .running(running),
        .step_ack(step_ack), .sc_wrap(sc_wrap), .instr_count(instr_count)
    );

    timing_sequencer #(.NUM_T(8), .CNT_W(16)) dut8 (
        .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
        .step_mode(step_mode), .step_req(step_req), .incr_sc(incr_sc),
        .clr_sc(clr_sc), .ien(ien), .irq_pending(irq_pending), .clr_r(clr_r),
        .advance_en(advance_en8), .sc(sc8), .T(T8), .R(R8), .running(running8),
        .step_ack(step_ack8), .sc_wrap(sc_wrap8), .instr_count(instr_count8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic clear_inputs();
        start = 0; halt_req = 0; step_mode = 0; step_req = 0; incr_sc = 0;
        clr_sc = 0; ien = 0; irq_pending = 0; clr_r = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;

        // Reset values
        check("rst_sc", 32'(sc), 0);
        check("rst_T", 32'(T), 32'h0001);
        check("rst_R", 32'(R), 0);
        check("rst_running", 32'(running), 0);
        check("rst_adv", 32'(advance_en), 0);
        check("rst_ack", 32'(step_ack), 0);
        check("rst_wrap", 32'(sc_wrap), 0);
        check("rst_icnt", 32'(instr_count), 0);

        // HALT ignores incr_sc
        incr_sc = 1;
        cycle(2);
        check("halt_hold_sc", 32'(sc), 0);

        // Start, then 5 increments
        incr_sc = 0; start = 1;
        cycle(1);
        start = 0; incr_sc = 1;
        cycle(5);
        incr_sc = 0; #1;
        check("run_sc5", 32'(sc), 5);
        check("run_T5", 32'(T), 32'h0020);
        check("run_running", 32'(running), 1);
        check("run_adv", 32'(advance_en), 1);

        // clr_sc beats incr_sc, and retires
        clr_sc = 1;
        cycle(1);
        clr_sc = 0; incr_sc = 1;
        cycle(3);
        incr_sc = 0;
        check("pre_clr_sc3", 32'(sc), 3);
        check("pre_clr_icnt", 32'(instr_count), 1);
        clr_sc = 1; incr_sc = 1;
        cycle(1);
        clr_sc = 0; incr_sc = 0; #1;
        check("clr_sc0", 32'(sc), 0);
        check("clr_T0", 32'(T), 32'h0001);
        check("clr_icnt", 32'(instr_count), 2);

        // halt_req beats incr_sc
        incr_sc = 1;
        cycle(3);
        halt_req = 1;
        cycle(1);
        halt_req = 0; #1;
        check("hlt_running", 32'(running), 0);
        check("hlt_adv", 32'(advance_en), 0);
        check("hlt_sc", 32'(sc), 0);
        check("hlt_icnt", 32'(instr_count), 3);
        cycle(3);
        incr_sc = 0;
        check("hlt_stay_sc", 32'(sc), 0);
        check("hlt_stay_running", 32'(running), 0);

        // Single-step with start held high throughout
        do_reset();
        step_mode = 1; start = 1;
        cycle(1);
        incr_sc = 1; #1;
        check("step_running", 32'(running), 1);
        check("step_idle_adv", 32'(advance_en), 0);
        exp_sc = 0;
        for (int c = 1; c <= 12; c++) begin
            exp_ack = (c == 5) || (c == 9) || (c == 10);
            step_req = exp_ack;
            #1;
            check($sformatf("step_ack_c%0d", c), 32'(step_ack), 32'(exp_ack));
            check($sformatf("step_adv_c%0d", c), 32'(advance_en), 32'(exp_ack));
            check($sformatf("step_sc_c%0d", c), 32'(sc), 32'(exp_sc));
            cycle(1);
            if (exp_ack) exp_sc++;
        end
        step_req = 0; #1;
        check("step_sc_final", 32'(sc), 3);
        // Leaving step mode resumes RUN
        step_mode = 0; incr_sc = 0; start = 0;
        cycle(1);
        check("step_to_run_adv", 32'(advance_en), 1);

        // Interrupt-cycle flop
        do_reset();
        start = 1;
        cycle(1);
        start = 0; ien = 1; incr_sc = 1;
        cycle(3);
        incr_sc = 0;
        check("irq_pre_R", 32'(R), 0);
        irq_pending = 1;
        cycle(1);
        check("irq_set_R", 32'(R), 1);
        clr_r = 1;
        cycle(1);
        clr_r = 0; irq_pending = 0;
        check("irq_clr_R", 32'(R), 0);
        clr_sc = 1;
        cycle(1);
        clr_sc = 0; irq_pending = 1;
        cycle(1);
        check("irq_T0_R", 32'(R), 0);
        irq_pending = 0; incr_sc = 1;
        cycle(3);
        incr_sc = 0; irq_pending = 1;
        cycle(1);
        check("irq_reset_pre_R", 32'(R), 1);
        // Asynchronous reset mid-cycle
        #2 reset = 1'b1;
        #1;
        check("async_R", 32'(R), 0);
        check("async_sc", 32'(sc), 0);
        check("async_running", 32'(running), 0);
        @(negedge clk);
        reset = 1'b0;
        clear_inputs();

        // Wrap on the NUM_T=8 instance
        do_reset();
        start = 1;
        cycle(1);
        start = 0; incr_sc = 1;
        cycle(7);
        check("wrap8_sc7", 32'(sc8), 7);
        check("wrap8_pre", 32'(sc_wrap8), 0);
        check("wrap8_T7", 32'(T8), 32'h80);
        cycle(1);
        incr_sc = 0; #1;
        check("wrap8_sc0", 32'(sc8), 0);
        check("wrap8_flag", 32'(sc_wrap8), 1);
        check("wrap16_sc8", 32'(sc), 8);
        check("wrap16_flag", 32'(sc_wrap), 0);
        clr_sc = 1;
        cycle(1);
        clr_sc = 0; #1;
        check("wrap8_sticky", 32'(sc_wrap8), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/timing_sequencer.md
Name: timing_sequencer

Overview:
Parametrised timing and run-control unit for the Basic Computer controller family. It replaces the fixed 4-bit sequence counter, 4-to-16 T decoder and hand-gated start/stop flop with one block. The block adds a configurable T-state count, an explicit HALT/RUN/STEP state machine with a single-step handshake, an interrupt-cycle flop (R), wrap detection, and an instruction-retire counter. It sits between the combinational control logic and every datapath enable. All datapath control strobes are ANDed with `advance_en`.

Parameters:
- NUM_T, 16: number of timing states T0..T(NUM_T-1); legal range 2..64. Localparam SC_W = $clog2(NUM_T).
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk, input, 1: system clock; all state changes on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- start, input, 1: leave HALT; ignored in other states.
- halt_req, input, 1: HLT decoded by the control logic; sampled only when advance_en=1.
- step_mode, input, 1: 1 = single-step operation.
- step_req, input, 1: one-cycle request to execute one T-state while in STEP_WAIT.
- incr_sc, input, 1: advance the sequence counter.
- clr_sc, input, 1: return the sequence counter to T0.
- ien, input, 1: interrupt enable flag.
- irq_pending, input, 1: FGI|FGO.
- clr_r, input, 1: clear R (end of interrupt cycle).
- advance_en, output, 1: this cycle's control strobes are live (replaces ~S gating).
- sc, output, SC_W: current sequence count.
- T, output, NUM_T: one-hot decode of sc.
- R, output, 1: interrupt-cycle flop.
- running, output, 1: state != HALT.
- step_ack, output, 1: pulses when a step_req is accepted.
- sc_wrap, output, 1: sticky; incr_sc was applied at sc=NUM_T-1.
- instr_count, output, CNT_W: number of retired instructions.

Behaviour:
- Reset (asynchronous):
  - state=HALT, sc=0, T=1 (T0 only), R=0, sc_wrap=0, instr_count=0.
  - Outputs: advance_en=0, step_ack=0, running=0.
- States: HALT, RUN, STEP_WAIT. `advance_en` is combinational:
  - RUN: advance_en=1.
  - STEP_WAIT: advance_en=step_req.
  - HALT: advance_en=0.
- HALT:
  - start=1 → next state is STEP_WAIT if step_mode=1, else RUN.
  - sc stays 0.
- RUN:
  - step_mode=1 → next state STEP_WAIT; the current cycle still advances.
- STEP_WAIT:
  - step_mode=0 → RUN.
  - step_req=1 → advance_en=1 and step_ack=1 in the same cycle (zero latency); state stays STEP_WAIT.
  - step_ack is never asserted outside STEP_WAIT.
- SC update, applied only when advance_en=1, in priority order:
  1. halt_req: sc←0 and state←HALT. Overrides clr_sc, incr_sc and step_mode.
  2. clr_sc: sc←0.
  3. incr_sc: at sc=NUM_T-1, sc←0 and sc_wrap←1; otherwise sc←sc+1.
  4. None asserted: hold.
- When advance_en=0: sc, R and instr_count hold.
- T is always the one-hot decode of the registered sc, with no extra latency.
- R flop, updated only when advance_en=1:
  - Set when R=0, T0=T1=T2=0, ien=1 and irq_pending=1.
  - clr_r clears R and takes priority over set.
- instr_count:
  - Increments by 1 when advance_en=1 and (clr_sc=1 or halt_req=1).
  - Wraps modulo 2^CNT_W.
- sc_wrap clears only on reset.
- Reset asserted mid-instruction aborts immediately to the reset values. No pending step or R is retained.
- start held high continuously has no effect outside HALT.

Test Plan:
- Reset, then start=1 for 1 cycle, then incr_sc=1 for 5 cycles → sc=5, T=16'h0020, running=1, advance_en=1.
- In RUN at sc=3, assert clr_sc and incr_sc together → sc=0, T=16'h0001, instr_count increments by 1.
- At sc=3 assert halt_req and incr_sc → next cycle state=HALT, sc=0, advance_en=0, running=0. Further incr_sc pulses leave sc=0 until start.
- step_mode=1, start, incr_sc held high, step_req pulsed 3 times at cycles 5, 9 and 10 → sc=3; step_ack high exactly in those 3 cycles; sc held between pulses.
- ien=1, irq_pending=1, sc=3 (T3) in RUN → R=1 next edge. A later clr_r with advance_en=1 gives R=0; irq_pending=1 while T0 is active does not set R.
- NUM_T=8: incr_sc for 8 cycles from sc=0 → sc back to 0, sc_wrap=1, and sc_wrap stays 1 after clr_sc.
